// File: rtl/bip_control_fsm_if.sv
// ---------------------------------------------------------------------------
// bip_control_fsm_if
// Bundles the fetch bus, accumulator status flags and datapath control lines
// of the BIP control unit.
//   master : the control FSM (consumes instruction/flags, drives controls)
//   slave  : program memory / datapath side (drives instruction/flags)
// Signals:
//   i_instr, i_valid        instruction word and its valid qualifier
//   i_acc_zero, i_acc_neg   accumulator status flags
//   o_PC, o_signal          fetch address and latched operand field
//   o_selA, o_selB, o_OP    datapath operand/operation selects
//   o_WrAcc, o_WrRam,
//   o_RdRam                 datapath strobes
//   o_halt                  core halted
// ---------------------------------------------------------------------------
interface bip_control_fsm_if #(
  parameter int N_BUS  = 16,
  parameter int N_ADDR = 11,
  parameter int TAM    = 2
);
  logic [N_BUS-1:0]  i_instr;
  logic              i_valid;
  logic              i_acc_zero;
  logic              i_acc_neg;
  logic [N_ADDR-1:0] o_PC;
  logic [N_ADDR-1:0] o_signal;
  logic [TAM-1:0]    o_selA;
  logic              o_selB;
  logic              o_WrAcc;
  logic              o_OP;
  logic              o_WrRam;
  logic              o_RdRam;
  logic              o_halt;

  modport master (
    input  i_instr, i_valid, i_acc_zero, i_acc_neg,
    output o_PC, o_signal, o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam,
           o_halt
  );

  modport slave (
    output i_instr, i_valid, i_acc_zero, i_acc_neg,
    input  o_PC, o_signal, o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam,
           o_halt
  );
endinterface

// File: rtl/bip_control_fsm.sv
// ---------------------------------------------------------------------------
// bip_control_fsm
// Control unit of the BIP accumulator core. A three-state FSM
// (FETCH -> EXEC -> FETCH, or EXEC -> HALT) fetches one instruction word,
// latches opcode and operand into the instruction register and drives the
// datapath controls for exactly one EXEC cycle. The PC advances at the end of
// EXEC (PC+1 with natural wrap, or a branch target).
//
// Ports:
//   i_clk      sole clock, rising edge
//   i_reset    synchronous, active-high reset
//   bus        bip_control_fsm_if.master:
//                i_instr/i_valid      instruction fetch input
//                i_acc_zero/i_acc_neg accumulator flags, sampled in EXEC
//                o_PC, o_signal       fetch address, IR operand field
//                o_selA/o_selB/o_OP   datapath selects
//                o_WrAcc/o_WrRam/o_RdRam strobes, active in EXEC only
//                o_halt               high while in HALT
//
// Optional feature: define BIP_BRANCH_EN to decode JMP/BEQ/BNE/BLT
// (opcodes 01000-01011). Without it those opcodes execute as NOP.
//
// All outputs come straight from flops. The control flops are loaded with
// the decode of the *next* state and IR, so they are valid in the very cycle
// the FSM is in EXEC and there is no combinational path from i_instr or
// i_valid to any output.
// ---------------------------------------------------------------------------
module bip_control_fsm #(
  parameter int N_BUS    = 16,
  parameter int N_ADDR   = 11,
  parameter int N_OP     = 5,
  parameter int TAM      = 2,
  parameter int RESET_PC = 0
) (
  input logic               i_clk,
  input logic               i_reset,
  bip_control_fsm_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAM-1:0] sel_a;
    logic           sel_b;
    logic           op;
    logic           wr_acc;
    logic           wr_ram;
    logic           rd_ram;
    logic           halt;
  } ctrl_t;

  localparam logic [N_OP-1:0] OP_HLT  = N_OP'(5'd0);
  localparam logic [N_OP-1:0] OP_STO  = N_OP'(5'd1);
  localparam logic [N_OP-1:0] OP_LD   = N_OP'(5'd2);
  localparam logic [N_OP-1:0] OP_LDI  = N_OP'(5'd3);
  localparam logic [N_OP-1:0] OP_ADD  = N_OP'(5'd4);
  localparam logic [N_OP-1:0] OP_ADDI = N_OP'(5'd5);
  localparam logic [N_OP-1:0] OP_SUB  = N_OP'(5'd6);
  localparam logic [N_OP-1:0] OP_SUBI = N_OP'(5'd7);
`ifdef BIP_BRANCH_EN
  localparam logic [N_OP-1:0] OP_JMP  = N_OP'(5'd8);
  localparam logic [N_OP-1:0] OP_BEQ  = N_OP'(5'd9);
  localparam logic [N_OP-1:0] OP_BNE  = N_OP'(5'd10);
  localparam logic [N_OP-1:0] OP_BLT  = N_OP'(5'd11);
`endif

  localparam logic [N_ADDR-1:0] PC_RST = N_ADDR'(RESET_PC);

  // Datapath controls for one EXEC cycle of the given opcode. HLT, branches
  // and every undefined opcode produce no strobes.
  function automatic ctrl_t decode_exec(input logic [N_OP-1:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_STO: begin
        c.wr_ram = 1'b1;
      end
      OP_LD: begin
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd0);
      end
      OP_LDI: begin
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd1);
      end
      OP_ADD: begin
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd2);
        c.sel_b  = 1'b0;
        c.op     = 1'b0;
      end
      OP_ADDI: begin
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd2);
        c.sel_b  = 1'b1;
        c.op     = 1'b0;
      end
      OP_SUB: begin
        c.rd_ram = 1'b1;
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd2);
        c.sel_b  = 1'b0;
        c.op     = 1'b1;
      end
      OP_SUBI: begin
        c.wr_acc = 1'b1;
        c.sel_a  = TAM'(2'd2);
        c.sel_b  = 1'b1;
        c.op     = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic [N_OP-1:0]   opcode_r;
  logic [N_OP-1:0]   opcode_next_s;
  logic [N_ADDR-1:0] operand_r;
  logic [N_ADDR-1:0] operand_next_s;
  logic [N_ADDR-1:0] pc_r;
  logic [N_ADDR-1:0] pc_next_s;
  logic              taken_s;
  ctrl_t             ctrl_r;
  ctrl_t             ctrl_next_s;

  // Next-state, IR load and PC update logic.
  always_comb begin
    state_next_s   = state_r;
    opcode_next_s  = opcode_r;
    operand_next_s = operand_r;
    pc_next_s      = pc_r;
    taken_s        = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (bus.i_valid) begin
          state_next_s   = ST_EXEC;
          opcode_next_s  = bus.i_instr[N_BUS-1 -: N_OP];
          operand_next_s = bus.i_instr[N_ADDR-1:0];
        end else begin
          // Fetch wait: PC and IR hold.
          state_next_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
`ifdef BIP_BRANCH_EN
        // Flags are sampled here, in the EXEC cycle itself.
        case (opcode_r)
          OP_JMP:  taken_s = 1'b1;
          OP_BEQ:  taken_s = bus.i_acc_zero;
          OP_BNE:  taken_s = ~bus.i_acc_zero;
          OP_BLT:  taken_s = bus.i_acc_neg;
          default: taken_s = 1'b0;
        endcase
`else
        taken_s = 1'b0;
`endif
        if (taken_s) begin
          pc_next_s = operand_r;
        end else begin
          // Natural N_ADDR-bit wrap: all-ones + 1 -> 0.
          pc_next_s = pc_r + N_ADDR'(1'b1);
        end
        if (opcode_r == OP_HLT) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT; i_valid is ignored.
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // Control values to present during the next cycle, from next state and IR.
  always_comb begin
    ctrl_next_s = '0;
    case (state_next_s)
      ST_EXEC: begin
        ctrl_next_s = decode_exec(opcode_next_s);
      end
      ST_HALT: begin
        ctrl_next_s.halt = 1'b1;
      end
      default: begin
        ctrl_next_s = '0;
      end
    endcase
  end

  // FSM state register; reset wins over everything in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction register, program counter and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      opcode_r  <= '0;
      operand_r <= '0;
      pc_r      <= PC_RST;
      ctrl_r    <= '0;
    end else begin
      opcode_r  <= opcode_next_s;
      operand_r <= operand_next_s;
      pc_r      <= pc_next_s;
      ctrl_r    <= ctrl_next_s;
    end
  end

  assign bus.o_PC     = pc_r;
  assign bus.o_signal = operand_r;
  assign bus.o_selA   = ctrl_r.sel_a;
  assign bus.o_selB   = ctrl_r.sel_b;
  assign bus.o_OP     = ctrl_r.op;
  assign bus.o_WrAcc  = ctrl_r.wr_acc;
  assign bus.o_WrRam  = ctrl_r.wr_ram;
  assign bus.o_RdRam  = ctrl_r.rd_ram;
  assign bus.o_halt   = ctrl_r.halt;

endmodule

// File: doc/bip_control_fsm.md
BIP_CONTROL_FSM -- requirements
Module: bip_control_fsm

Interface
REQ-001 SHALL have parameter N_BUS, default 16: instruction width.
REQ-002 SHALL have parameter N_ADDR, default 11: PC and operand width; N_ADDR <= N_BUS-N_OP.
REQ-003 SHALL have parameter N_OP, default 5: opcode width, opcode = i_instr[N_BUS-1 -: N_OP].
REQ-004 SHALL have parameter TAM, default 2: selA width.
REQ-005 SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-006 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_instr, input, N_BUS: instruction word from program memory.
REQ-009 SHALL have port i_valid, input, 1: i_instr valid this cycle.
REQ-010 SHALL have port i_acc_zero, input, 1: accumulator == 0.
REQ-011 SHALL have port i_acc_neg, input, 1: accumulator MSB.
REQ-012 SHALL have port o_PC, output, N_ADDR: fetch address.
REQ-013 SHALL have port o_signal, output, N_ADDR: operand field i_instr[N_ADDR-1:0] latched in IR.
REQ-014 SHALL have ports o_selA (TAM), o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam, all outputs: datapath controls.
REQ-015 SHALL have port o_halt, output, 1: core halted.

Function
REQ-016 SHALL implement FSM FETCH, EXEC, HALT; FETCH -> EXEC on i_valid; EXEC -> FETCH, or EXEC -> HALT on HLT; HALT exits only on reset.
REQ-017 SHALL latch i_instr into IR on the FETCH cycle with i_valid=1; i_valid SHALL be ignored in EXEC and HALT.
REQ-018 SHALL drive all control outputs from state and IR only, with no combinational path from i_instr or i_valid; latency is one cycle from instruction acceptance to control assertion.
REQ-019 SHALL assert o_WrAcc, o_WrRam, o_RdRam only in EXEC and hold them low in FETCH and HALT.
REQ-020 SHALL decode in EXEC as follows:
- 00000 HLT: no strobes.
- 00001 STO: WrRam.
- 00010 LD: RdRam, WrAcc, selA=0.
- 00011 LDI: WrAcc, selA=1.
- 00100 ADD: RdRam, WrAcc, selA=2, selB=0, OP=0.
- 00101 ADDI: WrAcc, selA=2, selB=1, OP=0.
- 00110 SUB: as ADD with OP=1.
- 00111 SUBI: as ADDI with OP=1.
REQ-021 SHALL treat any undefined opcode as NOP: no strobes, PC+1.
REQ-022 SHALL update PC at the end of EXEC only, to PC+1 modulo 2^N_ADDR, so all-ones wraps to 0, unless a taken branch applies.
REQ-023 SHALL sample i_acc_zero and i_acc_neg in the EXEC cycle.
REQ-024 SHALL keep PC unchanged through FETCH wait cycles and in HALT.
REQ-025 SHALL keep o_halt low in all states except HALT.

Reset
REQ-026 SHALL, on i_reset=1 at a rising edge in any state (mid-EXEC included), set state=FETCH, PC=RESET_PC, IR=0, o_signal=0, all strobes, o_OP, o_selB, o_selA and o_halt to 0.
REQ-027 SHALL give i_reset priority over i_valid and over a branch in the same cycle.

Configuration
REQ-028 SHALL, with macro BIP_BRANCH_EN defined, decode the following, where a taken branch loads PC with o_signal and a not-taken branch uses PC+1:
- 01000 JMP: unconditional.
- 01001 BEQ: taken if i_acc_zero.
- 01010 BNE: taken if !i_acc_zero.
- 01011 BLT: taken if i_acc_neg.
REQ-029 SHALL, without BIP_BRANCH_EN, treat 01000-01011 as NOP per REQ-021.

Verification
REQ-030 SHALL cover reset: RESET_PC=5, pulse i_reset -> o_PC=5, o_halt=0, all strobes 0 on the next cycle.
REQ-031 SHALL cover basic execution: i_instr=16'h1803 (LDI 3), i_valid=1 in FETCH -> next cycle o_WrAcc=1, o_selA=1, o_signal=3; PC 0 -> 1.
REQ-032 SHALL cover stall and wrap: i_valid=0 for 4 cycles -> PC stable, strobes 0; PC=2047 then NOP -> PC=0.
REQ-033 SHALL cover branching with BIP_BRANCH_EN: BEQ 16'h4864 with i_acc_zero=1 -> PC=100; same with i_acc_zero=0 -> PC+1; without macro -> PC+1.
REQ-034 SHALL cover halt: HLT 16'h0000 -> o_halt=1 from the next cycle, PC frozen, further i_valid ignored until reset.
REQ-035 SHALL cover reset during execution: i_reset asserted in the EXEC of STO -> o_WrRam=0 next cycle, state FETCH, PC=RESET_PC.
